fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Upstream stage of the single-cycle datapath. Replaces the manual switch address with a sequenced instruction address.
- Drives the 4-bit instruction-memory address (`pc`) and the register-bank write strobe (`reg_write`).
- Instructions execute one at a time, either single-stepped from a push-button or free-running at a divided rate. Execution halts after the last program address.
- Each instruction gets a settle window before its one-cycle write pulse, so the memory, bank and ALU path is stable when the write is committed.

Parameters:
- ADDR_W, 4: width of the instruction address.
- LAST_ADDR, 15: final program address; sequencing halts after executing it. Must be ≤ 2^ADDR_W-1.
- SETTLE, 2: cycles the FETCH state holds before the write pulse. Must be ≥ 1.
- TICK_DIV, 25000000: cycles spent in WAIT between instructions in run mode. Must be ≥ 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- run  in  1  level; 1 = free-running mode. Already synchronous to clk.
- step  in  1  raw push-button; asynchronous, synchronized internally.
- load  in  1  one-cycle request to set the address.
- load_addr  in  ADDR_W  address loaded when `load`=1.
- pc  out  ADDR_W  instruction-memory address.
- reg_write  out  1  register-bank write enable, one-cycle pulse.
- busy  out  1  high in FETCH, WRITE, ADVANCE and WAIT.
- halted  out  1  high in HALT.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE, pc=0, reg_write=0, busy=0, halted=0.
  - Step synchronizer, edge register and all counters cleared.
  - rst overrides every other input.
- Step input path:
  - Two-flop synchronizer, then a rising-edge detector.
  - `step_rise` is high for exactly one cycle, 3 clk edges after `step` rises.
  - Holding `step` high produces one event only.
- States: IDLE, FETCH, WRITE, ADVANCE, WAIT, HALT.
- IDLE:
  - If run=1 or step_rise=1, go to FETCH; otherwise stay.
  - busy=0.
- FETCH:
  - Lasts exactly SETTLE cycles, then goes to WRITE.
  - `pc` is stable throughout; step_rise is ignored.
- WRITE:
  - Lasts exactly 1 cycle with reg_write=1. reg_write is 0 in every other state.
  - Next state is ADVANCE.
- ADVANCE (1 cycle):
  - If pc==LAST_ADDR: pc holds, next state is HALT.
  - Otherwise pc<=pc+1. Next state is WAIT if run=1, else IDLE.
- WAIT:
  - Counter runs 0..TICK_DIV-1. After TICK_DIV cycles, go to FETCH.
  - If run=0 during any WAIT cycle, go to IDLE next cycle with the counter cleared.
  - step_rise is ignored.
- HALT:
  - halted=1, busy=0, pc holds.
  - run and step_rise are ignored. HALT is left only via rst or load.
- Load:
  - Takes effect in any state: pc<=load_addr, state<=IDLE, halted<=0, counters cleared.
  - If load is asserted while in WRITE, reg_write is still 1 for that cycle. The write has already been committed at that edge.
  - Load has priority over run, step_rise and ADVANCE.
- Latency:
  - Step mode: step_rise to reg_write pulse is 1 + SETTLE cycles; pc updates 2 cycles after the pulse.
  - Run mode: per-instruction period is SETTLE + 2 + TICK_DIV cycles.
- Arithmetic:
  - pc increments modulo 2^ADDR_W.
  - No wrap occurs in normal flow because of the HALT rule at LAST_ADDR.
- Outputs are registered with no combinational path from inputs: busy and halted are state-decoded from the state register, and reg_write is registered.

Test Plan:
- Reset with step pulse, SETTLE=2: rst held 2 cycles → pc=0, reg_write=0, halted=0. Then one step pulse of 5 cycles → exactly one reg_write pulse 3 cycles after step_rise, pc=1 two cycles later, state returns to IDLE.
- Run mode, TICK_DIV=4, SETTLE=2, LAST_ADDR=3: run=1 from IDLE → reg_write pulses spaced 8 cycles apart, pc sequence 0,1,2,3 with 4 pulses total. halted=1 after the 4th pulse and pc stays 3.
- Run dropped mid-WAIT: run=0 on the 2nd WAIT cycle → IDLE next cycle, no further reg_write pulses, pc retained.
- Load out of HALT: while halted, load=1 with load_addr=9 → next cycle pc=9, halted=0, IDLE. A following step executes address 9, then pc=10.
- Load versus step: load and step_rise in the same IDLE cycle → pc=load_addr, no FETCH entered, no reg_write.
- Mid-operation reset: rst asserted in FETCH and in WAIT → next cycle IDLE, pc=0, reg_write=0, busy=0, no pending pulse afterwards.

Source files
------------

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_sequencer
// Purpose  : Sequences instruction addresses (single-step or free-running)
//            and issues one register-bank write pulse per instruction.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_sequencer #(
    parameter int ADDR_W    = 4,
    parameter int LAST_ADDR = 15,
    parameter int SETTLE    = 2,
    parameter int TICK_DIV  = 25000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              step,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_addr,
    output logic [ADDR_W-1:0] pc,
    output logic              reg_write,
    output logic              busy,
    output logic              halted
);

    localparam int c_SETTLE_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int c_TICK_W   = $clog2(TICK_DIV);

    localparam logic [c_SETTLE_W-1:0] c_SETTLE_LAST = c_SETTLE_W'(SETTLE - 1);
    localparam logic [c_TICK_W-1:0]   c_TICK_LAST   = c_TICK_W'(TICK_DIV - 1);
    localparam logic [ADDR_W-1:0]     c_LAST_ADDR   = ADDR_W'(LAST_ADDR);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_WRITE   = 3'd2,
        S_ADVANCE = 3'd3,
        S_WAIT    = 3'd4,
        S_HALT    = 3'd5
    } state_t;

    logic                  r_step_meta;
    logic                  r_step_sync;
    logic                  r_step_prev;
    logic                  r_step_rise;

    state_t                r_state;
    logic [c_SETTLE_W-1:0] r_settle_cnt;
    logic [c_TICK_W-1:0]   r_tick_cnt;
    logic [ADDR_W-1:0]     r_pc;
    logic                  r_reg_write;

    // Push-button path: two-flop synchronizer, then a registered rising edge
    always_ff @(posedge clk) begin
        if (rst) begin
            r_step_meta <= 1'b0;
            r_step_sync <= 1'b0;
            r_step_prev <= 1'b0;
            r_step_rise <= 1'b0;
        end else begin
            r_step_meta <= step;
            r_step_sync <= r_step_meta;
            r_step_prev <= r_step_sync;
            r_step_rise <= r_step_sync & ~r_step_prev;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_pc         <= '0;
            r_settle_cnt <= '0;
            r_tick_cnt   <= '0;
            r_reg_write  <= 1'b0;
        end else if (load) begin
            r_state      <= S_IDLE;
            r_pc         <= load_addr;
            r_settle_cnt <= '0;
            r_tick_cnt   <= '0;
            r_reg_write  <= 1'b0;
        end else begin
            r_reg_write <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (run || r_step_rise) begin
                        r_state      <= S_FETCH;
                        r_settle_cnt <= '0;
                    end
                end
                S_FETCH: begin
                    // The write strobe is raised on the same edge that enters WRITE
                    if (r_settle_cnt == c_SETTLE_LAST) begin
                        r_state      <= S_WRITE;
                        r_settle_cnt <= '0;
                        r_reg_write  <= 1'b1;
                    end else begin
                        r_settle_cnt <= r_settle_cnt + 1'b1;
                    end
                end
                S_WRITE: begin
                    r_state <= S_ADVANCE;
                end
                S_ADVANCE: begin
                    if (r_pc == c_LAST_ADDR) begin
                        r_state <= S_HALT;
                    end else begin
                        r_pc       <= r_pc + 1'b1;
                        r_tick_cnt <= '0;
                        r_state    <= run ? S_WAIT : S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (!run) begin
                        r_state    <= S_IDLE;
                        r_tick_cnt <= '0;
                    end else if (r_tick_cnt == c_TICK_LAST) begin
                        r_state    <= S_FETCH;
                        r_tick_cnt <= '0;
                    end else begin
                        r_tick_cnt <= r_tick_cnt + 1'b1;
                    end
                end
                S_HALT: begin
                    r_state <= S_HALT;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign pc        = r_pc;
    assign reg_write = r_reg_write;
    assign busy      = (r_state == S_FETCH) || (r_state == S_WRITE) ||
                       (r_state == S_ADVANCE) || (r_state == S_WAIT);
    assign halted    = (r_state == S_HALT);

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_sequencer
// Purpose  : Directed and randomized checks of fetch_sequencer against a
//            phase-counting reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_sequencer;

    localparam int ADDR_W    = 4;
    localparam int LAST_ADDR = 3;
    localparam int SETTLE    = 2;
    localparam int TICK_DIV  = 4;
    localparam int PERIOD    = SETTLE + 2 + TICK_DIV;

    logic              clk = 1'b0;
    logic              rst;
    logic              run;
    logic              step;
    logic              load;
    logic [ADDR_W-1:0] load_addr;
    logic [ADDR_W-1:0] pc;
    logic              reg_write;
    logic              busy;
    logic              halted;

    always #5 clk = ~clk;

    fetch_sequencer #(
        .ADDR_W    (ADDR_W),
        .LAST_ADDR (LAST_ADDR),
        .SETTLE    (SETTLE),
        .TICK_DIV  (TICK_DIV)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .step      (step),
        .load      (load),
        .load_addr (load_addr),
        .pc        (pc),
        .reg_write (reg_write),
        .busy      (busy),
        .halted    (halted)
    );

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int pulses      = 0;
    int pulse_cyc[$];

    // Reference model: instruction progress is one phase number counted
    // from the start of FETCH; step history holds the sampled button values.
    bit m_active = 1'b0;
    bit m_halted = 1'b0;
    bit m_rw     = 1'b0;
    int m_phase  = 0;
    int m_pc     = 0;
    bit hist[4]  = '{default: 1'b0};

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed=%0d expected=%0d (cycle %0d)", tag, observed, expected, cyc);
        end
    endtask

    task automatic model_step(input bit r, input bit l, input int a, input bit ru, input bit s);
        bit rise;
        rise    = hist[2] & ~hist[3];
        hist[3] = hist[2];
        hist[2] = hist[1];
        hist[1] = hist[0];
        hist[0] = s;
        m_rw    = 1'b0;
        if (r) begin
            hist     = '{default: 1'b0};
            m_active = 1'b0;
            m_halted = 1'b0;
            m_pc     = 0;
        end else if (l) begin
            m_pc     = a;
            m_active = 1'b0;
            m_halted = 1'b0;
        end else if (m_halted) begin
            m_halted = 1'b1;
        end else if (!m_active) begin
            if (ru || rise) begin
                m_active = 1'b1;
                m_phase  = 0;
            end
        end else if (m_phase < SETTLE - 1) begin
            m_phase++;
        end else if (m_phase == SETTLE - 1) begin
            m_phase++;
            m_rw = 1'b1;
        end else if (m_phase == SETTLE) begin
            m_phase++;
        end else if (m_phase == SETTLE + 1) begin
            if (m_pc == LAST_ADDR) begin
                m_active = 1'b0;
                m_halted = 1'b1;
            end else begin
                m_pc = (m_pc + 1) % (1 << ADDR_W);
                if (ru) m_phase++;
                else    m_active = 1'b0;
            end
        end else begin
            if (!ru)                               m_active = 1'b0;
            else if (m_phase == PERIOD - 1)        m_phase = 0;
            else                                   m_phase++;
        end
    endtask

    task automatic tick(input bit r, input bit ru, input bit s, input bit l, input int a);
        rst       = r;
        run       = ru;
        step      = s;
        load      = l;
        load_addr = ADDR_W'(a);
        @(posedge clk);
        cyc++;
        model_step(r, l, a, ru, s);
        #1;
        check("pc", 32'(pc), 32'(m_pc));
        check("reg_write", 32'(reg_write), 32'(m_rw));
        check("busy", 32'(busy), 32'(m_active));
        check("halted", 32'(halted), 32'(m_halted));
        if (reg_write === 1'b1) begin
            pulses++;
            pulse_cyc.push_back(cyc);
        end
    endtask

    task automatic press(input int n_high, input int n_low);
        for (int i = 0; i < n_high; i++) tick(1'b0, 1'b0, 1'b1, 1'b0, 0);
        for (int i = 0; i < n_low; i++)  tick(1'b0, 1'b0, 1'b0, 1'b0, 0);
    endtask

    initial begin
        int  step_cyc;
        bit  reached;
        bit  rnd_run;
        bit  rnd_step;

        rst = 1'b1; run = 1'b0; step = 1'b0; load = 1'b0; load_addr = '0;

        // Reset, then one held push-button press
        tick(1'b1, 1'b0, 1'b0, 1'b0, 0);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 0);
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b0, 1'b0, 0);
        pulses = 0;
        pulse_cyc.delete();
        step_cyc = cyc + 1;
        press(5, 12);
        check("step_pulses", 32'(pulses), 32'd1);
        if (pulse_cyc.size() > 0) check("step_latency", 32'(pulse_cyc[0] - step_cyc), 32'(3 + SETTLE));
        check("step_pc", 32'(pc), 32'd1);

        // Free-running from address 0 to the halt address
        tick(1'b1, 1'b0, 1'b0, 1'b0, 0);
        pulses = 0;
        pulse_cyc.delete();
        reached = 1'b0;
        for (int i = 0; i < 60 && !reached; i++) begin
            tick(1'b0, 1'b1, 1'b0, 1'b0, 0);
            if (halted === 1'b1) reached = 1'b1;
        end
        check("run_reach_halt", 32'(reached), 32'd1);
        check("run_pulses", 32'(pulses), 32'(LAST_ADDR + 1));
        for (int i = 1; i < pulse_cyc.size(); i++)
            check("run_spacing", 32'(pulse_cyc[i] - pulse_cyc[i-1]), 32'(PERIOD));
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, 1'b1, 1'b0, 0);
        check("halt_no_more_pulses", 32'(pulses), 32'(LAST_ADDR + 1));
        check("halt_pc", 32'(pc), 32'(LAST_ADDR));

        // Load out of HALT, then single-step the loaded address
        tick(1'b0, 1'b0, 1'b0, 1'b1, 9);
        check("load_pc", 32'(pc), 32'd9);
        check("load_halted", 32'(halted), 32'd0);
        pulses = 0;
        press(5, 12);
        check("load_step_pulses", 32'(pulses), 32'd1);
        check("load_step_pc", 32'(pc), 32'd10);

        // Run dropped on the second WAIT cycle
        reached = 1'b0;
        for (int i = 0; i < 20 && !reached; i++) begin
            tick(1'b0, 1'b1, 1'b0, 1'b0, 0);
            if (m_active && m_phase == SETTLE + 3) reached = 1'b1;
        end
        check("wait_reach", 32'(reached), 32'd1);
        pulses = 0;
        tick(1'b0, 1'b0, 1'b0, 1'b0, 0);
        check("wait_drop_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 10; i++) tick(1'b0, 1'b0, 1'b0, 1'b0, 0);
        check("wait_drop_pulses", 32'(pulses), 32'd0);
        check("wait_drop_pc", 32'(pc), 32'd11);

        // Load and step_rise arriving in the same IDLE cycle
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b1, 1'b0, 0);
        pulses = 0;
        tick(1'b0, 1'b0, 1'b1, 1'b1, 5);
        check("ld_vs_step_pc", 32'(pc), 32'd5);
        press(3, 8);
        check("ld_vs_step_pulses", 32'(pulses), 32'd0);

        // Reset during FETCH and during WAIT
        tick(1'b0, 1'b1, 1'b0, 1'b0, 0);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 0);
        check("rst_fetch_pc", 32'(pc), 32'd0);
        pulses = 0;
        for (int i = 0; i < 10; i++) tick(1'b0, 1'b0, 1'b0, 1'b0, 0);
        check("rst_fetch_pulses", 32'(pulses), 32'd0);
        reached = 1'b0;
        for (int i = 0; i < 20 && !reached; i++) begin
            tick(1'b0, 1'b1, 1'b0, 1'b0, 0);
            if (m_active && m_phase >= SETTLE + 2) reached = 1'b1;
        end
        check("rst_wait_reach", 32'(reached), 32'd1);
        tick(1'b1, 1'b1, 1'b0, 1'b0, 0);
        check("rst_wait_busy", 32'(busy), 32'd0);
        pulses = 0;
        for (int i = 0; i < 10; i++) tick(1'b0, 1'b0, 1'b0, 1'b0, 0);
        check("rst_wait_pulses", 32'(pulses), 32'd0);

        // Randomized traffic checked cycle by cycle against the model
        rnd_run  = 1'b0;
        rnd_step = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(15, 0) == 0) rnd_run  = ~rnd_run;
            if ($urandom_range(5, 0) == 0)  rnd_step = ~rnd_step;
            tick($urandom_range(199, 0) == 0, rnd_run, rnd_step,
                 $urandom_range(39, 0) == 0, int'($urandom_range(15, 0)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
